render_engine_param: RTL and testbench
======================================

Name: render_engine_param

Overview:
Parametrised successor to the GPU render module. It accepts one render command (op, start/end coordinates, colour) and streams one pixel write per clock to the frame-buffer writer: x, y, pix_color and an enable strobe. Adds configurable resolution, a colour channel, all-octant lines, a filled-rectangle op and a busy flag. Sits between the command decoder and the frame-buffer write port.

Parameters:
XRES, 320, horizontal resolution in pixels
YRES, 240, vertical resolution in pixels
XBITS, 9, x coordinate width; must satisfy 2^XBITS >= XRES
YBITS, 8, y coordinate width; must satisfy 2^YBITS >= YRES
COLOR_W, 1, pixel colour width

Ports:
clk  in  1  system clock, all state on rising edge
n_rst  in  1  asynchronous active-low reset
start_l  in  XBITS+YBITS  start point, {x,y}
end_l  in  XBITS+YBITS  end point, {x,y}
op  in  3  0=CLEAR, 1=NOOP, 6=DRAW_LINE, 7=FILL_RECT; all other codes are treated as NOOP
color  in  COLOR_W  draw colour
render_enable  in  1  level request
x  out  XBITS  pixel x
y  out  YBITS  pixel y
pix_color  out  COLOR_W  pixel colour
enable  out  1  pixel write strobe, one pixel per cycle
render_done  out  1  command complete
busy  out  1  high from SETUP through the last pixel

Behaviour:
- Reset: all outputs 0; state IDLE; internal registers cleared. Reset asserted mid-command aborts immediately, with no further pixels.
- FSM states: IDLE, SETUP, CLEAR, LINE, RECT, DONE.
- IDLE: when render_enable=1, capture start_l, end_l, op and color, then go to SETUP. Inputs are ignored outside IDLE.
- SETUP (1 cycle): compute per-op registers. NOOP goes directly to DONE with no pixels.
- First enable is asserted in the cycle after SETUP. Outputs x, y, pix_color and enable are registered and valid together.
- CLEAR:
  - Row-major scan x=0..XRES-1 within y=0..YRES-1; pix_color=0.
  - Exactly XRES*YRES strobes.
- LINE (Bresenham, all octants):
  - Setup: dx=|x1-x0|, dy=-|y1-y0|, sx/sy=±1, err=dx+dy. err is signed, max(XBITS,YBITS)+2 bits.
  - Each cycle: emit (x,y). If (x,y)=(x1,y1), go to DONE.
  - Otherwise e2=2*err. If e2>=dy: err+=dy, x+=sx. If e2<=dx: err+=dx, y+=sy. Both updates use the same-cycle err.
  - Pixel count = max(dx,-dy)+1. A zero-length line emits 1 pixel.
- RECT:
  - Corners are normalised to min/max in SETUP.
  - Row-major scan from (xmin,ymin) to (xmax,ymax) inclusive.
  - Count = (xmax-xmin+1)*(ymax-ymin+1).
- DONE:
  - render_done=1, enable=0, busy=0.
  - Stays in DONE while render_enable=1; goes to IDLE in the cycle render_enable is seen 0. This prevents re-triggering a held request.
- render_enable dropped mid-command is ignored; the command runs to completion.
- busy=1 in SETUP, CLEAR, LINE and RECT.
- Coordinates >= XRES/YRES are emitted unmodified unless clipping is compiled in.

Optional Feature:
RENDER_CLIP_EN
- Defined:
  - In LINE/RECT, enable is forced to 0 for any pixel with x>=XRES or y>=YRES.
  - Stepping and cycle count are unchanged.
  - A RECT whose xmin>=XRES or ymin>=YRES goes from SETUP straight to DONE.
- Undefined: no range check; every stepped pixel strobes enable. Behaviour and area match an unclipped build.

Test Plan:
1. Reset for 2 cycles, then CLEAR with render_enable=1 -> 76800 strobes; first (0,0), last (319,239); pix_color=0; render_done=1 the cycle after the last strobe; back to IDLE after render_enable=0.
2. DRAW_LINE (10,10)->(12,12), color=1 -> exactly 3 strobes (10,10),(11,11),(12,12), then render_done.
3. DRAW_LINE (0,239)->(319,0), and DRAW_LINE (300,40)->(238,189) -> 320 and 150 strobes respectively; endpoints exact; each step changes x and y by at most 1.
4. DRAW_LINE (159,40)->(159,40) -> 1 strobe at (159,40). NOOP -> 0 strobes, render_done 2 cycles after the request.
5. FILL_RECT (4,4)->(2,3) -> 6 strobes (2,3),(3,3),(4,3),(2,4),(3,4),(4,4).
6. n_rst low after 50 pixels of a line -> all outputs 0 asynchronously; IDLE. With RENDER_CLIP_EN, DRAW_LINE (300,10)->(330,10) -> 31 steps, 20 strobes (x 300..319).

Source files
------------

// File: rtl/render_engine_param_if.sv
// render_engine_param_if: command inputs and pixel-stream outputs between the
// command decoder (master), the render engine (slave) and the frame-buffer writer.
interface render_engine_param_if #(
    parameter int XBITS   = 9,
    parameter int YBITS   = 8,
    parameter int COLOR_W = 1
);
    logic [XBITS+YBITS-1:0] start_l;
    logic [XBITS+YBITS-1:0] end_l;
    logic [2:0]             op;
    logic [COLOR_W-1:0]     color;
    logic                   render_enable;

    logic [XBITS-1:0]       x;
    logic [YBITS-1:0]       y;
    logic [COLOR_W-1:0]     pix_color;
    logic                   enable;
    logic                   render_done;
    logic                   busy;

    modport master (
        output start_l, end_l, op, color, render_enable,
        input  x, y, pix_color, enable, render_done, busy
    );

    modport slave (
        input  start_l, end_l, op, color, render_enable,
        output x, y, pix_color, enable, render_done, busy
    );
endinterface

// File: rtl/render_engine_param.sv
// render_engine_param: streams one pixel per clock for CLEAR, DRAW_LINE and FILL_RECT commands.
// Define RENDER_CLIP_EN to suppress the strobe for off-screen LINE/RECT pixels.
module render_engine_param #(
    parameter int XRES    = 320,
    parameter int YRES    = 240,
    parameter int XBITS   = 9,
    parameter int YBITS   = 8,
    parameter int COLOR_W = 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    render_engine_param_if.slave bus
);
    localparam int EW = ((XBITS > YBITS) ? XBITS : YBITS) + 2;
    localparam logic [2:0] OP_CLEAR = 3'd0;
    localparam logic [2:0] OP_LINE  = 3'd6;
    localparam logic [2:0] OP_RECT  = 3'd7;

    typedef enum logic [2:0] {IDLE, SETUP, CLEAR, LINE, RECT, DONE} state_t;
    state_t state, state_next;

    logic [2:0]           op_r;
    logic [COLOR_W-1:0]   color_r, pix_color_r;
    logic [XBITS-1:0]     x0_r, x1_r, cur_x, nx;
    logic [YBITS-1:0]     y0_r, y1_r, cur_y, ny;
    logic                 enable_r, sx_neg, sy_neg;
    logic signed [EW-1:0] dx_r, dy_r, err_r;

    logic [XBITS-1:0]     x_lo, x_hi, adx;
    logic [YBITS-1:0]     y_lo, y_hi, ady;
    logic signed [EW:0]   e2, dx_x, dy_x, err_sum;
    logic                 step_x, step_y, at_end;
    logic                 next_ok, line_ok, rect_ok;

    // CLEAR and RECT share one row-major scanner: x0_r/x1_r hold the x span, y1_r the last row.
    always_comb begin
        x_lo   = (x0_r < x1_r) ? x0_r : x1_r;
        x_hi   = (x0_r < x1_r) ? x1_r : x0_r;
        y_lo   = (y0_r < y1_r) ? y0_r : y1_r;
        y_hi   = (y0_r < y1_r) ? y1_r : y0_r;
        adx    = x_hi - x_lo;
        ady    = y_hi - y_lo;
        at_end = (cur_x == x1_r) && (cur_y == y1_r);

        e2     = {err_r, 1'b0};
        dx_x   = {dx_r[EW-1], dx_r};
        dy_x   = {dy_r[EW-1], dy_r};
        step_x = (e2 >= dy_x);
        step_y = (e2 <= dx_x);
        err_sum = {err_r[EW-1], err_r};
        if (step_x) err_sum = err_sum + dy_x;
        if (step_y) err_sum = err_sum + dx_x;

        if (state == LINE) begin
            nx = step_x ? (sx_neg ? cur_x - XBITS'(1) : cur_x + XBITS'(1)) : cur_x;
            ny = step_y ? (sy_neg ? cur_y - YBITS'(1) : cur_y + YBITS'(1)) : cur_y;
        end else if (cur_x == x1_r) begin
            nx = x0_r;
            ny = cur_y + YBITS'(1);
        end else begin
            nx = cur_x + XBITS'(1);
            ny = cur_y;
        end
    end

`ifdef RENDER_CLIP_EN
    assign next_ok = ({1'b0, nx} < (XBITS+1)'(XRES)) && ({1'b0, ny} < (YBITS+1)'(YRES));
    assign line_ok = ({1'b0, x0_r} < (XBITS+1)'(XRES)) && ({1'b0, y0_r} < (YBITS+1)'(YRES));
    assign rect_ok = ({1'b0, x_lo} < (XBITS+1)'(XRES)) && ({1'b0, y_lo} < (YBITS+1)'(YRES));
`else
    assign next_ok = 1'b1;
    assign line_ok = 1'b1;
    assign rect_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (bus.render_enable) state_next = SETUP;
            SETUP: begin
                case (op_r)
                    OP_CLEAR: state_next = CLEAR;
                    OP_LINE:  state_next = LINE;
                    OP_RECT:  state_next = rect_ok ? RECT : DONE;
                    default:  state_next = DONE;
                endcase
            end
            CLEAR, LINE, RECT: if (at_end) state_next = DONE;
            DONE:  if (!bus.render_enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            op_r        <= '0;
            color_r     <= '0;
            pix_color_r <= '0;
            x0_r        <= '0;
            x1_r        <= '0;
            y0_r        <= '0;
            y1_r        <= '0;
            cur_x       <= '0;
            cur_y       <= '0;
            enable_r    <= 1'b0;
            sx_neg      <= 1'b0;
            sy_neg      <= 1'b0;
            dx_r        <= '0;
            dy_r        <= '0;
            err_r       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    enable_r <= 1'b0;
                    if (bus.render_enable) begin
                        x0_r    <= bus.start_l[XBITS+YBITS-1:YBITS];
                        y0_r    <= bus.start_l[YBITS-1:0];
                        x1_r    <= bus.end_l[XBITS+YBITS-1:YBITS];
                        y1_r    <= bus.end_l[YBITS-1:0];
                        op_r    <= bus.op;
                        color_r <= bus.color;
                    end
                end
                SETUP: begin
                    pix_color_r <= color_r;
                    case (op_r)
                        OP_CLEAR: begin
                            x0_r        <= '0;
                            x1_r        <= XBITS'(XRES - 1);
                            y1_r        <= YBITS'(YRES - 1);
                            cur_x       <= '0;
                            cur_y       <= '0;
                            pix_color_r <= '0;
                            enable_r    <= 1'b1;
                        end
                        OP_LINE: begin
                            cur_x    <= x0_r;
                            cur_y    <= y0_r;
                            dx_r     <= EW'(adx);
                            dy_r     <= EW'(0) - EW'(ady);
                            err_r    <= EW'(adx) - EW'(ady);
                            sx_neg   <= (x1_r < x0_r);
                            sy_neg   <= (y1_r < y0_r);
                            enable_r <= line_ok;
                        end
                        OP_RECT: begin
                            x0_r     <= x_lo;
                            x1_r     <= x_hi;
                            y1_r     <= y_hi;
                            cur_x    <= x_lo;
                            cur_y    <= y_lo;
                            enable_r <= rect_ok;
                        end
                        default: enable_r <= 1'b0;
                    endcase
                end
                CLEAR, LINE, RECT: begin
                    if (at_end) begin
                        enable_r <= 1'b0;
                    end else begin
                        cur_x    <= nx;
                        cur_y    <= ny;
                        enable_r <= next_ok;
                        if (state == LINE) err_r <= err_sum[EW-1:0];
                    end
                end
                default: enable_r <= 1'b0;
            endcase
        end
    end

    assign bus.x           = cur_x;
    assign bus.y           = cur_y;
    assign bus.pix_color   = pix_color_r;
    assign bus.enable      = enable_r;
    assign bus.render_done = (state == DONE);
    assign bus.busy        = (state == SETUP) || (state == CLEAR) || (state == LINE) || (state == RECT);
endmodule

// File: tb/tb_render_engine_param.sv
// tb_render_engine_param: table vectors, hand-written corner sequences and random commands
// checked against a pixel-list reference model of render_engine_param.
module tb_render_engine_param;
    localparam int XRES    = 320;
    localparam int YRES    = 240;
    localparam int XBITS   = 9;
    localparam int YBITS   = 8;
    localparam int COLOR_W = 1;
    localparam int XMAX    = (1 << XBITS) - 1;
    localparam int YMAX    = (1 << YBITS) - 1;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] c;
    } pix_t;

    typedef struct {
        logic [2:0] op;
        int         x0, y0, x1, y1, c;
        int         cnt;
        int         fx, fy, lx, ly;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    render_engine_param_if #(.XBITS(XBITS), .YBITS(YBITS), .COLOR_W(COLOR_W)) bus ();

    render_engine_param #(
        .XRES(XRES), .YRES(YRES), .XBITS(XBITS), .YBITS(YBITS), .COLOR_W(COLOR_W)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus)
    );

    int   checks   = 0;
    int   failures = 0;
    pix_t got_q[$];
    pix_t exp_q[$];
    int   exp_steps;
    int   busy_cnt;
    bit   mon_on = 1'b0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.enable) got_q.push_back({16'(bus.x), 16'(bus.y), 16'(bus.pix_color)});
            if (bus.busy) busy_cnt++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit visible(input int x, input int y);
`ifdef RENDER_CLIP_EN
        return (x < XRES) && (y < YRES);
`else
        return 1'b1;
`endif
    endfunction

    // Expected pixel stream and stepping-cycle count, straight from the command rules.
    function automatic void model(input int op, input int x0, input int y0,
                                  input int x1, input int y1, input int c);
        int cm, x, y, dx, dy, sx, sy, err, e2, xl, xh, yl, yh;
        cm = c & ((1 << COLOR_W) - 1);
        exp_q.delete();
        exp_steps = 0;
        if (op == 0) begin
            for (int yy = 0; yy < YRES; yy++)
                for (int xx = 0; xx < XRES; xx++)
                    exp_q.push_back({16'(xx), 16'(yy), 16'(0)});
            exp_steps = XRES * YRES;
        end else if (op == 6) begin
            dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
            dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
            sx  = (x1 >= x0) ? 1 : -1;
            sy  = (y1 >= y0) ? 1 : -1;
            err = dx + dy;
            x   = x0;
            y   = y0;
            while (exp_steps < 5000) begin
                exp_steps++;
                if (visible(x, y)) exp_q.push_back({16'(x), 16'(y), 16'(cm)});
                if (x == x1 && y == y1) break;
                e2 = 2 * err;
                if (e2 >= dy) begin err += dy; x += sx; end
                if (e2 <= dx) begin err += dx; y += sy; end
            end
        end else if (op == 7) begin
            xl = (x0 < x1) ? x0 : x1;  xh = (x0 < x1) ? x1 : x0;
            yl = (y0 < y1) ? y0 : y1;  yh = (y0 < y1) ? y1 : y0;
            if (visible(xl, yl)) begin
                for (int yy = yl; yy <= yh; yy++)
                    for (int xx = xl; xx <= xh; xx++) begin
                        exp_steps++;
                        if (visible(xx, yy)) exp_q.push_back({16'(xx), 16'(yy), 16'(cm)});
                    end
            end
        end
    endfunction

    function automatic int pix_mismatches();
        int m = 0;
        int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i] != exp_q[i]) m++;
        return m;
    endfunction

    task automatic do_reset();
        bus.render_enable = 1'b0;
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 n_rst = 1'b1;
    endtask

    task automatic run_cmd(input string name, input logic [2:0] op_i, input int x0, input int y0,
                           input int x1, input int y1, input int c, input bit drop_early);
        int lat, held_n;
        bit seen;
        model(int'(op_i), x0, y0, x1, y1, c);
        @(posedge clk);
        #1;
        bus.op      = op_i;
        bus.start_l = {XBITS'(x0), YBITS'(y0)};
        bus.end_l   = {XBITS'(x1), YBITS'(y1)};
        bus.color   = COLOR_W'(c);
        got_q.delete();
        busy_cnt = 0;
        mon_on   = 1'b1;
        bus.render_enable = 1'b1;
        @(posedge clk);
        // Inputs are captured already; scrambling them must not change the command.
        #1;
        bus.op      = 3'($urandom);
        bus.start_l = (XBITS+YBITS)'($urandom);
        bus.end_l   = (XBITS+YBITS)'($urandom);
        bus.color   = COLOR_W'($urandom);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < exp_steps + 20) begin
            @(negedge clk);
            lat++;
            if (drop_early && lat == 2) bus.render_enable = 1'b0;
            if (bus.render_done) seen = 1'b1;
        end
        check({name, ".latency"}, seen ? lat : -1, exp_steps + 2);
        if (!seen) begin
            mon_on = 1'b0;
            do_reset();
            return;
        end
        if (!drop_early) begin
            held_n = got_q.size();
            repeat (2) @(negedge clk);
            check({name, ".done_held"}, bus.render_done, 1);
            check({name, ".no_retrigger"}, got_q.size(), held_n);
            bus.render_enable = 1'b0;
        end
        @(negedge clk);
        check({name, ".idle_after"}, {bus.render_done, bus.busy}, 0);
        mon_on = 1'b0;
        check({name, ".strobes"}, got_q.size(), exp_q.size());
        check({name, ".busy_cycles"}, busy_cnt, exp_steps + 1);
        check({name, ".pixels"}, pix_mismatches(), 0);
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    vec_t vecs[8];

    initial begin
        int steps_bad, pre_n, wait_n, rx, ry, kind;
        vecs[0] = '{3'd0, 0,   0,   0,   0,   1, 76800, 0,   0,   319, 239, "clear"};
        vecs[1] = '{3'd6, 10,  10,  12,  12,  1, 3,     10,  10,  12,  12,  "line_diag"};
        vecs[2] = '{3'd6, 0,   239, 319, 0,   1, 320,   0,   239, 319, 0,   "line_full"};
        vecs[3] = '{3'd6, 300, 40,  238, 189, 1, 150,   300, 40,  238, 189, "line_steep"};
        vecs[4] = '{3'd6, 159, 40,  159, 40,  1, 1,     159, 40,  159, 40,  "line_point"};
        vecs[5] = '{3'd1, 5,   5,   9,   9,   1, 0,     -1,  -1,  -1,  -1,  "noop"};
        vecs[6] = '{3'd7, 4,   4,   2,   3,   1, 6,     2,   3,   4,   4,   "rect_swap"};
        vecs[7] = '{3'd3, 1,   2,   3,   4,   1, 0,     -1,  -1,  -1,  -1,  "op3_noop"};

        bus.render_enable = 1'b0;
        bus.op      = '0;
        bus.start_l = '0;
        bus.end_l   = '0;
        bus.color   = '0;
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {bus.x, bus.y, bus.pix_color, bus.enable, bus.render_done, bus.busy}, 0);
        @(posedge clk);
        #1 n_rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].name, vecs[i].op, vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1,
                    vecs[i].c, 1'b0);
            check({vecs[i].name, ".count"}, got_q.size(), vecs[i].cnt);
            if (vecs[i].cnt > 0) begin
                check({vecs[i].name, ".first"},
                      (got_q.size() > 0) ? {16'(got_q[0].x), 16'(got_q[0].y)} : 32'hFFFF_FFFF,
                      {16'(vecs[i].fx), 16'(vecs[i].fy)});
                check({vecs[i].name, ".last"},
                      (got_q.size() > 0) ? {16'(got_q[$].x), 16'(got_q[$].y)} : 32'hFFFF_FFFF,
                      {16'(vecs[i].lx), 16'(vecs[i].ly)});
            end
            if (vecs[i].op == 3'd6) begin
                steps_bad = 0;
                for (int k = 1; k < got_q.size(); k++) begin
                    if ((int'(got_q[k].x) - int'(got_q[k-1].x)) > 1 || (int'(got_q[k-1].x) - int'(got_q[k].x)) > 1 ||
                        (int'(got_q[k].y) - int'(got_q[k-1].y)) > 1 || (int'(got_q[k-1].y) - int'(got_q[k].y)) > 1)
                        steps_bad++;
                end
                check({vecs[i].name, ".unit_steps"}, steps_bad, 0);
            end
        end

        // Clipping boundary: 31 steps; strobes stop at the right screen edge only when clipped.
        run_cmd("line_offscreen", 3'd6, 300, 10, 330, 10, 1, 1'b0);
`ifdef RENDER_CLIP_EN
        check("line_offscreen.count", got_q.size(), 20);
`else
        check("line_offscreen.count", got_q.size(), 31);
`endif
        check("line_offscreen.steps", busy_cnt, 32);

        // Asynchronous reset in the middle of a long line.
        @(posedge clk);
        #1;
        bus.op      = 3'd6;
        bus.start_l = {XBITS'(0), YBITS'(0)};
        bus.end_l   = {XBITS'(200), YBITS'(100)};
        got_q.delete();
        mon_on = 1'b1;
        bus.render_enable = 1'b1;
        wait_n = 0;
        while (got_q.size() < 50 && wait_n < 300) begin
            @(negedge clk);
            wait_n++;
        end
        check("abort.reached_50", got_q.size(), 50);
        bus.render_enable = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        check("abort.async_outputs", {bus.x, bus.y, bus.pix_color, bus.enable, bus.render_done, bus.busy}, 0);
        pre_n = got_q.size();
        repeat (3) @(negedge clk);
        check("abort.no_pixels", got_q.size(), pre_n);
        @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (3) @(negedge clk);
        mon_on = 1'b0;
        check("abort.idle", {bus.enable, bus.render_done, bus.busy}, 0);
        check("abort.no_restart", got_q.size(), pre_n);
        run_cmd("post_abort_noop", 3'd1, 0, 0, 0, 0, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 9));
            rx = int'($urandom_range(0, XMAX));
            ry = int'($urandom_range(0, YMAX));
            if (kind <= 4) begin
                run_cmd($sformatf("rnd%0d_line", i), 3'd6, rx, ry,
                        clampi(rx + int'($urandom_range(0, 80)) - 40, XMAX),
                        clampi(ry + int'($urandom_range(0, 80)) - 40, YMAX),
                        int'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            end else if (kind <= 8) begin
                run_cmd($sformatf("rnd%0d_rect", i), 3'd7, rx, ry,
                        clampi(rx + int'($urandom_range(0, 14)) - 7, XMAX),
                        clampi(ry + int'($urandom_range(0, 14)) - 7, YMAX),
                        int'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            end else begin
                run_cmd($sformatf("rnd%0d_noop", i), 3'($urandom_range(1, 5)), rx, ry, 0, 0,
                        1, $urandom_range(0, 1) == 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
